snake_engine: RTL and testbench

- Grid-based snake game core with a multi-segment body held in a ring buffer, an occupancy bitmap, food placement, growth, self/wall collision and a game-state FSM.
- Replaces the single-block, vsync-clocked mover. All logic runs on `clk`; vsync is only sampled as a frame strobe.
- Sits between the hvsync generator / input switches and the pixel renderer. The renderer reads cells through a combinational query port.

---
 rtl/snake_pkg.sv | 61 ++++++
 rtl/snake_ring.sv | 49 ++++
 rtl/snake_engine.sv | 211 +++++++++++++++++++++
 tb/tb_snake_engine.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared types and helpers for the snake game core.
// States, directions, LFSR constants and next-cell arithmetic.
package snake_pkg;

  localparam logic [2:0] ST_INIT   = 3'd0;
  localparam logic [2:0] ST_READY  = 3'd1;
  localparam logic [2:0] ST_PLAY   = 3'd2;
  localparam logic [2:0] ST_STEP   = 3'd3;
  localparam logic [2:0] ST_COMMIT = 3'd4;
  localparam logic [2:0] ST_FOOD   = 3'd5;
  localparam logic [2:0] ST_DEAD   = 3'd6;

  typedef enum logic [1:0] {
    DIR_LEFT  = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_UP    = 2'd2,
    DIR_DOWN  = 2'd3
  } dir_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef struct packed {
    logic        oob;
    logic [15:0] x;
    logic [15:0] y;
  } cell_t;

  function automatic dir_t opposite(dir_t d);
    return dir_t'(d ^ 2'd1);
  endfunction

  // Edge crossings always yield the wrapped cell; oob flags a wall hit.
  function automatic cell_t next_cell(
    logic [15:0] x, logic [15:0] y, dir_t d, int w, int h, bit wrap);
    cell_t c;
    c.oob = 1'b0;
    c.x   = x;
    c.y   = y;
    case (d)
      DIR_LEFT:
        if (x == 16'd0) begin
          c.x = 16'(w - 1); c.oob = !wrap;
        end else c.x = x - 16'd1;
      DIR_RIGHT:
        if (x == 16'(w - 1)) begin
          c.x = 16'd0; c.oob = !wrap;
        end else c.x = x + 16'd1;
      DIR_UP:
        if (y == 16'd0) begin
          c.y = 16'(h - 1); c.oob = !wrap;
        end else c.y = y - 16'd1;
      default:
        if (y == 16'(h - 1)) begin
          c.y = 16'd0; c.oob = !wrap;
        end else c.y = y + 16'd1;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/snake_ring.sv
// Body position ring buffer: head write port, tail read port.
// Length lives in the engine; the tail index is derived from it.
module snake_ring
  import snake_pkg::*;
#(
  parameter int MAX_LEN = 64,
  parameter int XW      = 5,
  parameter int YW      = 5,
  parameter int LW      = 7
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          wr_en,
  input  logic          wr_adv,
  input  logic [XW-1:0] wr_x,
  input  logic [YW-1:0] wr_y,
  input  logic [LW-1:0] len,
  output logic [XW-1:0] tail_x,
  output logic [YW-1:0] tail_y
);

  localparam int PW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  logic [PW-1:0]    head_ptr;
  logic [PW-1:0]    ptr_inc;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    tail_ptr;
  logic [XW+YW-1:0] mem [MAX_LEN];

  assign ptr_inc = (int'(head_ptr) == MAX_LEN - 1) ? '0
                 : head_ptr + 1'b1;
  assign wr_ptr  = wr_adv ? ptr_inc : head_ptr;

  assign tail_ptr = PW'((int'(head_ptr) + MAX_LEN + 1 - int'(len))
                        % MAX_LEN);
  assign {tail_x, tail_y} = mem[tail_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) head_ptr <= '0;
    else if (clr) head_ptr <= '0;
    else if (wr_en) head_ptr <= wr_ptr;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {wr_x, wr_y};
  end

endmodule

// File: rtl/snake_engine.sv
// Snake game core: FSM, occupancy bitmap, frame divider, food LFSR.
// Renderer reads cells combinationally through the query port.
module snake_engine
  import snake_pkg::*;
#(
  parameter int GRID_W   = 32,
  parameter int GRID_H   = 30,
  parameter int MAX_LEN  = 64,
  parameter int INIT_LEN = 3,
  parameter int TICK_DIV = 4,
  parameter int WRAP     = 1,
  parameter int XW       = $clog2(GRID_W),
  parameter int YW       = $clog2(GRID_H),
  parameter int LW       = $clog2(MAX_LEN + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          vsync,
  input  logic          start,
  input  logic [3:0]    dir_req,
  input  logic [XW-1:0] query_x,
  input  logic [YW-1:0] query_y,
  output logic          query_body,
  output logic          query_head,
  output logic          query_food,
  output logic [XW-1:0] head_x,
  output logic [YW-1:0] head_y,
  output logic [LW-1:0] length,
  output logic [15:0]   score,
  output logic [2:0]    state_o,
  output logic          game_over
);

  localparam int NC = GRID_W * GRID_H;
  localparam int BW = (NC > 1) ? $clog2(NC) : 1;

  logic [2:0]    state;
  logic [LW-1:0] ik;
  logic [NC-1:0] bm;
  logic [7:0]    fcnt;
  logic [8:0]    fcnt_inc;
  logic          vs1, vs2, vs3, frame;
  dir_t          dir, pend_dir, req_d;
  logic          req_v;
  logic [XW-1:0] food_x, nxt_x, nxt_xc, init_x, tail_x, cand_x, wr_x;
  logic [YW-1:0] food_y, nxt_y, nxt_yc, init_y, tail_y, cand_y, wr_y;
  logic          grow, grow_c, hit_c, cand_ok;
  logic          ring_clr, ring_wr, ring_adv;
  logic [15:0]   lfsr;
  cell_t         nc;

  function automatic logic [BW-1:0] cidx(logic [XW-1:0] x,
                                         logic [YW-1:0] y);
    return BW'(int'(y) * GRID_W + int'(x));
  endfunction

  function automatic logic in_grid(logic [XW-1:0] x, logic [YW-1:0] y);
    return (int'(x) < GRID_W) && (int'(y) < GRID_H);
  endfunction

  function automatic logic bm_at(logic [NC-1:0] b,
                                 logic [XW-1:0] x, logic [YW-1:0] y);
    return in_grid(x, y) ? b[cidx(x, y)] : 1'b0;
  endfunction

  assign frame    = vs2 & ~vs3;
  assign fcnt_inc = {1'b0, fcnt} + 9'(frame);

  always_comb begin
    req_v = 1'b1;
    req_d = DIR_LEFT;
    priority case (1'b1)
      dir_req[0]: req_d = DIR_LEFT;
      dir_req[1]: req_d = DIR_RIGHT;
      dir_req[2]: req_d = DIR_UP;
      dir_req[3]: req_d = DIR_DOWN;
      default:    req_v = 1'b0;
    endcase
  end

  assign nc     = next_cell(16'(head_x), 16'(head_y), pend_dir,
                            GRID_W, GRID_H, WRAP != 0);
  assign nxt_xc = XW'(nc.x);
  assign nxt_yc = YW'(nc.y);
  assign grow_c = (nxt_xc == food_x) && (nxt_yc == food_y);
  // Stepping onto the tail is fine unless the tail stays put (growth).
  assign hit_c  = nc.oob
                | (bm_at(bm, nxt_xc, nxt_yc)
                   & ~((nxt_xc == tail_x) && (nxt_yc == tail_y) && !grow_c));

  assign cand_x  = lfsr[XW-1:0];
  assign cand_y  = lfsr[XW+YW-1:XW];
  assign cand_ok = in_grid(cand_x, cand_y) && !bm_at(bm, cand_x, cand_y);

  assign init_x = XW'(GRID_W / 2 - INIT_LEN + int'(ik));
  assign init_y = YW'(GRID_H / 2);

  assign ring_clr = (state == ST_INIT) && (ik == '0);
  assign ring_wr  = ((state == ST_INIT) && (ik != '0))
                  || (state == ST_COMMIT);
  assign ring_adv = !((state == ST_INIT) && (ik == LW'(1)));
  assign wr_x     = (state == ST_INIT) ? init_x : nxt_x;
  assign wr_y     = (state == ST_INIT) ? init_y : nxt_y;

  snake_ring #(
    .MAX_LEN(MAX_LEN), .XW(XW), .YW(YW), .LW(LW)
  ) u_ring (
    .clk(clk), .reset(reset), .clr(ring_clr),
    .wr_en(ring_wr), .wr_adv(ring_adv),
    .wr_x(wr_x), .wr_y(wr_y), .len(length),
    .tail_x(tail_x), .tail_y(tail_y)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_INIT;
      ik       <= '0;
      bm       <= '0;
      length   <= '0;
      score    <= '0;
      dir      <= DIR_RIGHT;
      pend_dir <= DIR_RIGHT;
      food_x   <= XW'(GRID_W / 4);
      food_y   <= YW'(GRID_H / 2);
      lfsr     <= LFSR_SEED;
      fcnt     <= '0;
      {vs3, vs2, vs1} <= '0;
      head_x   <= '0;
      head_y   <= '0;
      nxt_x    <= '0;
      nxt_y    <= '0;
      grow     <= 1'b0;
    end else begin
      {vs3, vs2, vs1} <= {vs2, vs1, vsync};
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0);
      if ((state == ST_READY || state == ST_PLAY) && req_v
          && req_d != opposite(dir))
        pend_dir <= req_d;
      // Frames seen while a step is in flight are banked for PLAY.
      if (state == ST_STEP || state == ST_COMMIT || state == ST_FOOD)
        fcnt <= (fcnt_inc >= 9'(TICK_DIV)) ? 8'(TICK_DIV) : fcnt_inc[7:0];
      case (state)
        ST_INIT: begin
          if (ik == '0) begin
            bm     <= '0;
            length <= '0;
            ik     <= ik + 1'b1;
          end else begin
            bm[cidx(init_x, init_y)] <= 1'b1;
            head_x <= init_x;
            head_y <= init_y;
            if (ik == LW'(INIT_LEN)) begin
              length   <= LW'(INIT_LEN);
              dir      <= DIR_RIGHT;
              pend_dir <= DIR_RIGHT;
              ik       <= '0;
              state    <= ST_READY;
            end else ik <= ik + 1'b1;
          end
        end
        ST_READY: if (start) begin
          fcnt  <= '0;
          score <= '0;
          state <= ST_PLAY;
        end
        ST_PLAY: begin
          if (fcnt_inc >= 9'(TICK_DIV)) begin
            fcnt  <= '0;
            state <= ST_STEP;
          end else fcnt <= fcnt_inc[7:0];
        end
        ST_STEP: begin
          dir   <= pend_dir;
          nxt_x <= nxt_xc;
          nxt_y <= nxt_yc;
          grow  <= grow_c;
          state <= hit_c ? ST_DEAD : ST_COMMIT;
        end
        ST_COMMIT: begin
          if (!grow || length == LW'(MAX_LEN))
            bm[cidx(tail_x, tail_y)] <= 1'b0;
          bm[cidx(nxt_x, nxt_y)] <= 1'b1;
          head_x <= nxt_x;
          head_y <= nxt_y;
          if (grow) begin
            if (score != 16'hFFFF) score <= score + 16'd1;
            if (length < LW'(MAX_LEN)) length <= length + 1'b1;
          end
          state <= grow ? ST_FOOD : ST_PLAY;
        end
        ST_FOOD: if (cand_ok) begin
          food_x <= cand_x;
          food_y <= cand_y;
          state  <= ST_PLAY;
        end
        ST_DEAD: if (start) begin
          ik    <= '0;
          state <= ST_INIT;
        end
        default: state <= ST_INIT;
      endcase
    end
  end

  assign query_body = bm_at(bm, query_x, query_y);
  assign query_head = (query_x == head_x) && (query_y == head_y);
  assign query_food = (query_x == food_x) && (query_y == food_y);
  assign state_o    = state;
  assign game_over  = (state == ST_DEAD);

endmodule

// File: tb/tb_snake_engine.sv
// Directed bench for snake_engine: default instance (wrap) and a
// walled, longer, one-frame-per-step instance for death cases.
module tb_snake_engine;
  import snake_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       ra, va, sa, rb, vb, sb;
  logic [3:0] da, db;
  logic [4:0] qxa, qya, qxb, qyb;
  logic       qba, qha, qfa, qbb, qhb, qfb;
  logic [4:0] hxa, hya, hxb, hyb;
  logic [6:0] lna, lnb;
  logic [15:0] sca, scb;
  logic [2:0] sta, stb;
  logic       goa, gob;

  int checks = 0;
  int failures = 0;
  bit saw_food;

  snake_engine u_a (
    .clk(clk), .reset(ra), .vsync(va), .start(sa), .dir_req(da),
    .query_x(qxa), .query_y(qya), .query_body(qba), .query_head(qha),
    .query_food(qfa), .head_x(hxa), .head_y(hya), .length(lna),
    .score(sca), .state_o(sta), .game_over(goa)
  );

  snake_engine #(.INIT_LEN(5), .TICK_DIV(1), .WRAP(0)) u_b (
    .clk(clk), .reset(rb), .vsync(vb), .start(sb), .dir_req(db),
    .query_x(qxb), .query_y(qyb), .query_body(qbb), .query_head(qhb),
    .query_food(qfb), .head_x(hxb), .head_y(hyb), .length(lnb),
    .score(scb), .state_o(stb), .game_over(gob)
  );

  typedef struct {
    logic [3:0] d;
    int x;
    int y;
    int len;
    int sc;
  } vec_t;

  vec_t tv[25];

  task automatic chk(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask

  function automatic logic [2:0] st(input int s);
    return (s != 0) ? stb : sta;
  endfunction

  task automatic frame(input int s);
    if (s != 0) vb = 1'b1; else va = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        if (s != 0) vb = 1'b0; else va = 1'b0;
      end
      @(negedge clk);
      if (st(s) == ST_FOOD) saw_food = 1'b1;
    end
  endtask

  task automatic step(input int s, input logic [3:0] d);
    int n;
    if (s != 0) db = d; else da = d;
    repeat ((s != 0) ? 1 : 4) frame(s);
    n = 0;
    while (st(s) != ST_PLAY && st(s) != ST_DEAD && n < 50) begin
      @(negedge clk);
      if (st(s) == ST_FOOD) saw_food = 1'b1;
      n++;
    end
    if (n >= 50) chk("settle_timeout", int'(st(s)), int'(ST_PLAY));
    if (s != 0) db = 4'b0; else da = 4'b0;
  endtask

  task automatic qa(input int x, input int y);
    qxa = 5'(x);
    qya = 5'(y);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int nf, fb, r;
    bit lf, found;
    logic [3:0] sd[4];
    int sx[4], sy[4];

    for (int i = 0; i < 15; i++) tv[i] = '{4'b0000, 17 + i, 15, 3, 0};
    for (int i = 15; i < 23; i++) tv[i] = '{4'b0000, i - 15, 15, 3, 0};
    tv[23] = '{4'b0001, 8, 15, 4, 1};
    tv[24] = '{4'b0100, 8, 14, 4, 1};

    ra = 0; rb = 0; va = 0; vb = 0; sa = 0; sb = 0;
    da = 0; db = 0; qxa = 0; qya = 0; qxb = 0; qyb = 0;
    repeat (3) @(negedge clk);
    chk("rst_state", sta, ST_INIT);
    chk("rst_len", lna, 0);
    chk("rst_score", sca, 0);
    chk("rst_gameover", goa, 0);
    ra = 1; rb = 1;
    repeat (4) @(negedge clk);
    chk("init_state", sta, ST_READY);
    chk("init_len", lna, 3);
    chk("init_hx", hxa, 16);
    chk("init_hy", hya, 15);
    qa(14, 15); chk("init_bm14", qba, 1);
    qa(15, 15); chk("init_bm15", qba, 1);
    qa(16, 15); chk("init_bm16", qba, 1);
    chk("init_qhead", qha, 1);
    qa(17, 15); chk("init_bm17", qba, 0);
    qa(8, 15); chk("init_qfood", qfa, 1);
    qa(10, 31); chk("oob_query", qba, 0);
    @(negedge clk);
    repeat (4) @(negedge clk);
    chk("b_init_state", stb, ST_READY);
    chk("b_init_len", lnb, 5);
    chk("b_init_hx", hxb, 16);

    sa = 1; @(negedge clk); sa = 0;
    chk("play_state", sta, ST_PLAY);
    for (int i = 0; i < 25; i++) begin
      saw_food = 1'b0;
      step(0, tv[i].d);
      chk($sformatf("v%0d_hx", i), hxa, tv[i].x);
      chk($sformatf("v%0d_hy", i), hya, tv[i].y);
      chk($sformatf("v%0d_len", i), lna, tv[i].len);
      chk($sformatf("v%0d_score", i), sca, tv[i].sc);
      chk($sformatf("v%0d_state", i), sta, ST_PLAY);
      if (i == 1) begin
        qa(14, 15); chk("mv_bm14", qba, 0);
        qa(15, 15); chk("mv_bm15", qba, 0);
        qa(16, 15); chk("mv_bm16", qba, 1);
        qa(17, 15); chk("mv_bm17", qba, 1);
        qa(18, 15); chk("mv_bm18", qba, 1);
        @(negedge clk);
      end
      if (i == 23) begin
        chk("eat_saw_food", saw_food, 1);
        nf = 0; fb = 0;
        for (int y = 0; y < 30; y++)
          for (int x = 0; x < 32; x++) begin
            qa(x, y);
            if (qfa) begin nf++; fb = qba; end
          end
        chk("food_count", nf, 1);
        chk("food_on_body", fb, 0);
        @(negedge clk);
      end
    end

    qa(7, 14); lf = qfa; @(negedge clk);
    if (!lf) begin
      sd = '{4'b0001, 4'b1000, 4'b0010, 4'b0100};
      sx = '{7, 7, 8, 8}; sy = '{14, 15, 15, 14};
    end else begin
      sd = '{4'b0010, 4'b1000, 4'b0001, 4'b0100};
      sx = '{9, 9, 8, 8}; sy = '{14, 15, 15, 14};
    end
    for (r = 0; r < 8; r++) begin
      step(0, sd[r % 4]);
      chk($sformatf("sq%0d_hx", r), hxa, sx[r % 4]);
      chk($sformatf("sq%0d_hy", r), hya, sy[r % 4]);
      chk($sformatf("sq%0d_len", r), lna, 4);
      chk($sformatf("sq%0d_state", r), sta, ST_PLAY);
    end

    sb = 1; @(negedge clk); sb = 0;
    step(1, 4'b0100);
    chk("b_up_hy", hyb, 14);
    for (int i = 0; i < 8; i++) step(1, 4'b0001);
    chk("b_left_hx", hxb, 8);
    chk("b_left_hy", hyb, 14);
    db = 4'b1000; vb = 1; found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (i == 4) vb = 0;
      if (stb == ST_FOOD) begin
        found = 1;
        chk("b_eat_score", scb, 1);
        rb = 0;
        #1;
      end
    end
    chk("b_saw_food", found, 1);
    chk("b_rst_state", stb, ST_INIT);
    chk("b_rst_len", lnb, 0);
    chk("b_rst_score", scb, 0);
    db = 0; vb = 0;
    @(negedge clk); rb = 1;
    repeat (8) @(negedge clk);
    chk("b_reinit_state", stb, ST_READY);

    sb = 1; @(negedge clk); sb = 0;
    step(1, 4'b0100);
    step(1, 4'b0001);
    step(1, 4'b1000);
    chk("self_state", stb, ST_DEAD);
    chk("self_gameover", gob, 1);
    chk("self_hx", hxb, 15);
    chk("self_hy", hyb, 14);
    chk("self_len", lnb, 5);

    sb = 1; repeat (10) @(negedge clk); sb = 0;
    chk("b_replay_state", stb, ST_PLAY);
    for (int i = 0; i < 15; i++) step(1, 4'b0000);
    chk("wall_edge_hx", hxb, 31);
    chk("wall_edge_state", stb, ST_PLAY);
    step(1, 4'b0000);
    chk("wall_state", stb, ST_DEAD);
    chk("wall_gameover", gob, 1);
    chk("wall_hx", hxb, 31);
    chk("wall_hy", hyb, 15);
    frame(1);
    chk("dead_frozen_hx", hxb, 31);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
